// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//
// Iterative restoring radix-2 divider for the EX stage. Executes DIV (signed)
// and DIVU (unsigned), one quotient bit per clock, and delivers
// {remainder (HI), quotient (LO)} to the HI/LO write path.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   start      divide instruction valid in EX (held until ready is seen)
//   signed_div 1 = DIV (two's complement), 0 = DIVU
//   dividend   rs value, sampled only on the accept cycle
//   divisor    rt value, sampled only on the accept cycle
//   annul      kills the EX instruction, aborts any operation in progress
//   result     {remainder, quotient}, updated only when ready pulses
//   ready      one-cycle pulse, result valid in the same cycle
//   div_stall  combinational stall request to the hazard unit
// -----------------------------------------------------------------------------
module div_unit #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  signed_div,
   input  logic [DATA_W-1:0]     dividend,
   input  logic [DATA_W-1:0]     divisor,
   input  logic                  annul,
   output logic [2*DATA_W-1:0]   result,
   output logic                  ready,
   output logic                  div_stall
);

   localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DZERO,
      DONE
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    counter;
   logic [DATA_W-1:0]   rem_q;
   logic [DATA_W-1:0]   quo_q;
   logic [DATA_W-1:0]   dvs_q;
   logic                sign_q;
   logic                sign_r;

   logic                dividend_neg;
   logic                divisor_neg;
   logic [DATA_W-1:0]   dividend_mag;
   logic [DATA_W-1:0]   divisor_mag;
   logic [DATA_W:0]     shifted;
   logic [DATA_W:0]     trial;
   logic                trial_ok;
   logic [DATA_W-1:0]   rem_next;
   logic [DATA_W-1:0]   quo_next;
   logic [DATA_W-1:0]   quo_fixed;
   logic [DATA_W-1:0]   rem_fixed;

   // The stall holds F/D/E while the divide is outstanding; it drops in the
   // ready cycle so EX can advance, and annul always releases it.
   assign div_stall = start & ~ready & ~annul;

   // Operand magnitudes. Negating INT_MIN yields INT_MIN, which is the correct
   // unsigned magnitude 2^(DATA_W-1).
   assign dividend_neg = signed_div & dividend[DATA_W-1];
   assign divisor_neg  = signed_div & divisor[DATA_W-1];
   assign dividend_mag = dividend_neg ? -dividend : dividend;
   assign divisor_mag  = divisor_neg  ? -divisor  : divisor;

   // One restoring step: quo_q doubles as the dividend shift register, its MSB
   // feeds the partial remainder and the new quotient bit enters at the LSB.
   // The extra top bit of the trial subtraction is the borrow.
   assign shifted  = {rem_q, quo_q[DATA_W-1]};
   assign trial    = shifted - {1'b0, dvs_q};
   assign trial_ok = ~trial[DATA_W];
   assign rem_next = trial_ok ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
   assign quo_next = {quo_q[DATA_W-2:0], trial_ok};

   // Sign correction of the final step's values, applied as they are
   // registered into result on the edge that enters DONE.
   assign quo_fixed = sign_q ? -quo_next : quo_next;
   assign rem_fixed = sign_r ? -rem_next : rem_next;

   // Control FSM and datapath registers. ready and result are registered on
   // the transition into DONE, so they are valid throughout the DONE cycle and
   // result then holds until the next completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         counter <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         sign_q  <= 1'b0;
         sign_r  <= 1'b0;
         result  <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ready <= 1'b0;
               if (start && !annul) begin
                  counter <= '0;
                  rem_q   <= '0;
                  quo_q   <= dividend_mag;
                  dvs_q   <= divisor_mag;
                  sign_q  <= dividend_neg ^ divisor_neg;
                  sign_r  <= dividend_neg;
                  if (divisor == '0) begin
                     state <= DZERO;
                  end else begin
                     state <= BUSY;
                  end
               end
            end

            BUSY: begin
               if (annul) begin
                  state <= IDLE;
               end else begin
                  rem_q   <= rem_next;
                  quo_q   <= quo_next;
                  counter <= counter + CNT_W'(1);
                  if (counter == LAST_CNT) begin
                     state  <= DONE;
                     ready  <= 1'b1;
                     result <= {rem_fixed, quo_fixed};
                  end
               end
            end

            DZERO: begin
               if (annul) begin
                  state <= IDLE;
               end else begin
                  state  <= DONE;
                  ready  <= 1'b1;
                  result <= '0;
               end
            end

            DONE: begin
               // start seen here still belongs to the finishing instruction.
               ready <= 1'b0;
               state <= IDLE;
            end

            default: begin
               ready <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//
// Self-checking bench for div_unit (DATA_W = 32). A behavioural model tracks
// when each accepted divide must complete and what it must produce, using
// plain integer division; a negedge process compares ready, div_stall and
// result against it every cycle. Directed cases pin literal results and stall
// lengths; a randomized phase mixes signedness, corner operands and annuls.
// -----------------------------------------------------------------------------
module tb_div_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          signedDiv;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          annul;
   logic [2*W-1:0] result;
   logic          ready;
   logic          divStall;

   int checks   = 0;
   int failures = 0;
   int cycleNo  = 0;
   bit checkEn  = 1'b0;

   // Behavioural model state
   bit             expReady      = 1'b0;
   logic [2*W-1:0] expResult     = '0;
   logic [2*W-1:0] pendingResult = '0;
   int             countdown     = 0;

   div_unit #(.DATA_W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signedDiv),
      .dividend   (dividend),
      .divisor    (divisor),
      .annul      (annul),
      .result     (result),
      .ready      (ready),
      .div_stall  (divStall)
   );

   // Free-running clock and cycle counter
   always #5 clk = ~clk;

   always @(posedge clk) cycleNo++;

   // Reference arithmetic: {remainder, quotient} from plain integer division.
   // Signed division in 64 bits truncates toward zero with the remainder taking
   // the dividend's sign; INT_MIN / -1 wraps when cut back to 32 bits.
   function automatic logic [2*W-1:0] refDiv(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input bit sgn);
      longint sa, sb, q, r;
      logic [W-1:0] uq, ur;
      if (b == '0) return '0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[W-1:0], q[W-1:0]};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   // Timing model: an accepted divide completes DATA_W cycles later (one for a
   // zero divisor); annul while outstanding drops it; the completion cycle
   // ignores start.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         expReady  = 1'b0;
         expResult = '0;
         countdown = 0;
      end else if (expReady) begin
         expReady = 1'b0;
      end else if (countdown > 0) begin
         if (annul) begin
            countdown = 0;
         end else begin
            countdown--;
            if (countdown == 0) begin
               expReady  = 1'b1;
               expResult = pendingResult;
            end
         end
      end else if (start && !annul) begin
         pendingResult = refDiv(dividend, divisor, signedDiv);
         countdown     = (divisor == '0) ? 1 : W;
      end
   end

   task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                              input logic [2*W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d",
                  name, actual, expected, cycleNo);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (checkEn && !rst) begin
         checkOutput("ready", 64'(ready), 64'(expReady));
         checkOutput("div_stall", 64'(divStall), 64'(start & ~expReady & ~annul));
         checkOutput("result", result, expResult);
      end
   end

   // Issue one divide (caller is at posedge+1 of an IDLE cycle) and hold start
   // until ready; operands are scrambled after acceptance. Returns at posedge+1
   // of the cycle after ready with start still high.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit sgn, output int stallCycles,
                                output logic [2*W-1:0] res, output int readyCycle);
      bit gotReady;
      gotReady    = 1'b0;
      stallCycles = 0;
      res         = '0;
      readyCycle  = 0;
      dividend    = a;
      divisor     = b;
      signedDiv   = sgn;
      start       = 1'b1;
      for (int i = 0; i < 100 && !gotReady; i++) begin
         @(negedge clk);
         if (ready) begin
            gotReady   = 1'b1;
            res        = result;
            readyCycle = cycleNo;
         end else if (divStall) begin
            stallCycles++;
         end
         @(posedge clk);
         #1;
         if (!gotReady) begin
            dividend = $urandom;
            divisor  = $urandom;
         end
      end
      if (!gotReady) begin
         checks++;
         failures++;
         $display("[TB] FAIL ready_timeout no ready within 100 cycles, required 1");
      end
   endtask

   task automatic runCase(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit sgn,
                          input logic [2*W-1:0] expRes, input int expStall);
      int stall, rc;
      logic [2*W-1:0] res;
      applyStimulus(a, b, sgn, stall, res, rc);
      checkOutput(name, res, expRes);
      checkOutput({name, "_stall"}, 64'(stall), 64'(expStall));
      start = 1'b0;
   endtask

   // Global time bound
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired, simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   // Directed cases followed by randomized traffic
   initial begin
      int stall, rc1, rc2;
      logic [2*W-1:0] res;
      logic [W-1:0] a, b;
      bit sgn;
      int k;

      rst = 1'b1; start = 1'b0; annul = 1'b0; signedDiv = 1'b0;
      dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ready", 64'(ready), 64'(0));
      checkOutput("reset_result", result, 64'(0));
      checkOutput("reset_stall", 64'(divStall), 64'(0));
      rst = 1'b0;
      checkEn = 1'b1;
      @(posedge clk);
      #1;

      runCase("udiv_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
      @(posedge clk); #1;
      runCase("sdiv_m7_2", 32'hFFFFFFF9, 32'h2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33);
      @(posedge clk); #1;
      runCase("sdiv_7_m2", 32'h7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33);
      @(posedge clk); #1;

      // Annul in BUSY cycle 10: no ready, result keeps the previous value
      dividend = 32'h12345678; divisor = 32'h3; signedDiv = 1'b0; start = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      annul = 1'b1;
      @(negedge clk);
      checkOutput("annul_stall", 64'(divStall), 64'(0));
      @(posedge clk);
      #1;
      annul = 1'b0;
      checkOutput("annul_ready", 64'(ready), 64'(0));
      checkOutput("annul_keep", result, 64'h00000001_FFFFFFFD);
      runCase("after_annul", 32'hFFFFFFFF, 32'h10, 1'b0, 64'h0000000F_0FFFFFFF, 33);
      @(posedge clk); #1;

      runCase("div_zero", 32'h1234, 32'h0, 1'b0, 64'h0, 2);
      @(posedge clk); #1;

      // Back-to-back with start held
      applyStimulus(32'd50, 32'd5, 1'b0, stall, res, rc1);
      checkOutput("b2b_first", res, 64'h00000000_0000000A);
      applyStimulus(32'd9, 32'd4, 1'b0, stall, res, rc2);
      checkOutput("b2b_second", res, 64'h00000001_00000002);
      checkOutput("b2b_spacing", 64'(rc2 - rc1), 64'(34));
      start = 1'b0;
      @(posedge clk); #1;

      runCase("int_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33);
      @(posedge clk); #1;

      // Annul in IDLE suppresses both the accept and the stall
      dividend = 32'd77; divisor = 32'd3; start = 1'b1; annul = 1'b1;
      @(negedge clk);
      checkOutput("idle_annul_stall", 64'(divStall), 64'(0));
      @(posedge clk); #1;
      start = 1'b0; annul = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset in the middle of BUSY
      dividend = 32'd1000; divisor = 32'd3; signedDiv = 1'b0; start = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midrst_ready", 64'(ready), 64'(0));
      checkOutput("midrst_result", result, 64'(0));
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      runCase("after_reset", 32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, 33);
      @(posedge clk); #1;

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         sgn = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       a = 32'h80000000;
            1:       a = 32'($urandom_range(0, 255));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       b = 32'h0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFFFFFF;
            3:       b = 32'h80000000;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) begin
            dividend = a; divisor = b; signedDiv = sgn; start = 1'b1;
            k = (b == '0) ? 1 : $urandom_range(1, W);
            repeat (k) @(posedge clk);
            #1;
            annul = 1'b1;
            @(posedge clk); #1;
            annul = 1'b0;
            start = 1'b0;
            @(posedge clk); #1;
         end else begin
            runCase("rand", a, b, sgn, refDiv(a, b, sgn), (b == '0) ? 2 : 33);
            if ($urandom_range(0, 1) == 0) begin
               @(posedge clk); #1;
            end
         end
      end

      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative restoring radix-2 divider for the EX stage of the 5-stage MIPS pipeline; executes DIV and DIVU.
- Produces the quotient (LO) and remainder (HI), delivered to the HI/LO write path in MEM.
- Drives the `div_stall` request that the hazard unit consumes as its EX-stage divider stall input. That input freezes F/D/E and lets M/W drain.

Parameters:
- DATA_W, 32, operand width. Legal values are ≥ 2. Only 32 is used in the core.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  DIV/DIVU instruction valid in EX. Held high by the stalled EX stage until `ready` is seen.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  in  DATA_W  rs value, after forwarding. Sampled only on the accept cycle.
- divisor  in  DATA_W  rt value, after forwarding. Sampled only on the accept cycle.
- annul  in  1  flush/exception kill of the EX instruction. Aborts the operation in progress.
- result  out  2*DATA_W  {remainder (HI), quotient (LO)}.
- ready  out  1  one-cycle pulse; `result` is valid in the same cycle.
- div_stall  out  1  combinational: `start & ~ready & ~annul`.

Behaviour:
- Reset (asynchronous):
  - state = IDLE; counter = 0; internal registers = 0.
  - `result` = 0; `ready` = 0.
  - `div_stall` follows its equation; it is 0 whenever start = 0.
- States: IDLE, BUSY, DZERO, DONE.
- IDLE:
  - If `start & ~annul` and divisor == 0: go to DZERO.
  - Else if `start & ~annul`: go to BUSY. On that edge:
    - Latch the operand magnitudes: for a signed op, negate any negative operand. For an unsigned op, take operands as-is.
    - Latch sign_q = dividend[MSB] ^ divisor[MSB] and sign_r = dividend[MSB]. Both are forced to 0 when unsigned.
    - counter = 0; partial remainder = 0.
  - Otherwise remain in IDLE.
- BUSY: one quotient bit per cycle, DATA_W cycles in total.
  - Each cycle: shift the partial remainder left, bringing in the next dividend bit (MSB first).
  - Trial subtract the divisor magnitude using DATA_W+1 bits. If the result is non-negative, keep it and the quotient bit = 1; otherwise restore and the quotient bit = 0.
  - counter increments. When counter == DATA_W−1, go to DONE at the next edge.
- DZERO: one cycle, then go to DONE. The result is forced to quotient = 0, remainder = 0.
- DONE:
  - `ready` = 1 for exactly one cycle.
  - `result` carries the sign-corrected values: quotient negated if sign_q, remainder negated if sign_r.
  - Next state is IDLE unconditionally. `start` seen during DONE belongs to the finishing instruction and is ignored.
  - `result` holds its value after DONE until the next DONE or a reset.
- Latency:
  - Normal divide: accept edge → DATA_W BUSY cycles → DONE. `div_stall` is high for DATA_W+1 consecutive cycles (33 for DATA_W = 32), then low in the DONE cycle so EX advances.
  - Divide by zero: `div_stall` is high for 2 cycles.
- Back-to-back divides: the next instruction reaches EX in the cycle after DONE; IDLE accepts it then.
- Annul: in BUSY or DZERO, `annul` = 1 sends the block to IDLE at the next edge. `ready` is never asserted for the killed op and `result` is unchanged. `annul` in IDLE or DONE has no effect except suppressing the accept and the stall.
- Signed overflow: INT_MIN / −1 gives quotient = INT_MIN (wraps) and remainder = 0. No trap.
- Arithmetic rules:
  - Remainder magnitude is always less than divisor magnitude.
  - For signed ops the quotient truncates toward zero and the remainder takes the dividend's sign.
- Operands changing after acceptance have no effect on the result.

Test Plan:
- Unsigned 100 / 7: `start` = 1, signed_div = 0. Expect `div_stall` high for 33 cycles, then `ready` pulses for one cycle with result = {0x00000002, 0x0000000E}. The block is IDLE the following cycle.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002): quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF. Also signed 7 / −2: quotient = 0xFFFFFFFD, remainder = 0x00000001.
- Divide by zero, 0x1234 / 0: `div_stall` high for 2 cycles, `ready` in the 2nd cycle after accept, result = 0.
- Annul at BUSY cycle 10: block returns to IDLE, `ready` stays 0, `result` keeps its previous value. A new start on the next cycle completes with correct values (0xFFFFFFFF / 0x10 unsigned → quotient 0x0FFFFFFF, remainder 0xF).
- Back-to-back: `start` held through two DIVU ops (50/5, then 9/4). Expect two `ready` pulses 34 cycles apart with results {0, 10} and {1, 2}.
- INT_MIN / −1 signed: quotient 0x80000000, remainder 0. Separately, assert `rst` mid-BUSY: `ready` = 0 and `result` = 0 immediately, and the block is in IDLE.
